// File: rtl/nri_div_ctrl.sv
// Iterative non-restoring divider controller for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle; divide-by-zero and signed overflow take a one-cycle fast path.
module nri_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_reg, state_next;
  logic            op_rem_reg, op_rem_next;
  logic            neg_q_reg, neg_q_next;
  logic            neg_r_reg, neg_r_next;
  logic [XLEN:0]   r_reg, r_next;
  logic [XLEN-1:0] q_reg, q_next;
  logic [XLEN-1:0] d_reg, d_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  logic            accept;
  logic            is_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, sgn_ovf;
  logic [XLEN:0]   r_shift, r_step, r_fix;
  logic [XLEN-1:0] q_step, quo, rem;

  assign o_ready  = i_rst_n && (state_reg == IDLE) && !i_flush;
  assign o_valid  = (state_reg == DONE);
  assign o_busy   = (state_reg != IDLE);
  assign o_result = result_reg;
  assign accept   = i_valid && o_ready;

  // Operand conditioning: magnitudes for signed ops, raw values for unsigned ops.
  assign is_signed = ~i_op[0];
  assign a_neg     = is_signed & i_dividend[XLEN-1];
  assign b_neg     = is_signed & i_divisor[XLEN-1];
  assign a_mag     = a_neg ? -i_dividend : i_dividend;
  assign b_mag     = b_neg ? -i_divisor : i_divisor;
  assign div_zero  = (i_divisor == '0);
  assign sgn_ovf   = is_signed && (i_dividend == {1'b1, {(XLEN-1){1'b0}}}) && (i_divisor == '1);

  // The shifted value may wrap, but R stays within [-D, D) so the modular sum is exact.
  assign r_shift = {r_reg[XLEN-1:0], q_reg[XLEN-1]};
  assign r_step  = r_reg[XLEN] ? (r_shift + {1'b0, d_reg}) : (r_shift - {1'b0, d_reg});
  assign q_step  = {q_reg[XLEN-2:0], ~r_step[XLEN]};

  assign r_fix = r_reg[XLEN] ? (r_reg + {1'b0, d_reg}) : r_reg;
  assign quo   = neg_q_reg ? -q_reg : q_reg;
  assign rem   = neg_r_reg ? -r_fix[XLEN-1:0] : r_fix[XLEN-1:0];

  always_comb begin
    state_next  = state_reg;
    op_rem_next = op_rem_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    r_next      = r_reg;
    q_next      = q_reg;
    d_next      = d_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_rem_next = i_op[1];
          neg_q_next  = a_neg ^ b_neg;
          neg_r_next  = a_neg;
          d_next      = b_mag;
          if (div_zero) begin
            result_next = i_op[1] ? i_dividend : '1;
            state_next  = DONE;
          end else if (sgn_ovf) begin
            result_next = i_op[1] ? '0 : i_dividend;
            state_next  = DONE;
          end else begin
            r_next     = '0;
            q_next     = a_mag;
            cnt_next   = CW'(XLEN-1);
            state_next = CALC;
          end
        end
      end
      CALC: begin
        r_next   = r_step;
        q_next   = q_step;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        r_next      = r_fix;
        result_next = op_rem_reg ? rem : quo;
        state_next  = DONE;
      end
      DONE: begin
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A flush discards any pending result, so the result register must not move.
    if (i_flush) begin
      state_next  = IDLE;
      result_next = result_reg;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      op_rem_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      r_reg      <= '0;
      q_reg      <= '0;
      d_reg      <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      op_rem_reg <= op_rem_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      r_reg      <= r_next;
      q_reg      <= q_next;
      d_reg      <= d_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
    end
  end

endmodule
